// File: rtl/tinycpu_pkg.sv
// Shared types and defaults for the tinycpu memory arbiter.
package tinycpu_pkg;

  localparam int AW_DEF = 8;
  localparam int DW_DEF = 8;

  // One-hot arbiter FSM encoding
  typedef enum logic [2:0] {
    IDLE   = 3'b001,
    ACCESS = 3'b010,
    RESP   = 3'b100
  } arb_state_e;

  // Requester IDs, as carried in the grant/holding registers
  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_LDR = 1'b1;

endpackage

// File: rtl/tinycpu_rr_pick.sv
// Two-way round-robin picker with a loader lock override.
module tinycpu_rr_pick
  import tinycpu_pkg::*;
(
  input  logic cpu_req,
  input  logic ldr_req,
  input  logic last_ldr,
  input  logic ldr_lock,
  input  logic lock_hit,
  output logic pick_ldr,
  output logic valid
);

  // Lone requester wins; on a tie the port not granted last wins, unless the
  // loader holds an unexpired lock on top of its own previous grant.
  always_comb begin
    valid    = cpu_req | ldr_req;
    pick_ldr = REQ_CPU;
    if (ldr_req && !cpu_req)
      pick_ldr = REQ_LDR;
    else if (ldr_req && cpu_req)
      pick_ldr = !last_ldr || (ldr_lock && !lock_hit);
  end

endmodule

// File: rtl/tinycpu_mem_arb.sv
// Shares the single-port 256x8 SRAM between the CPU core and the loader port.
// Each access is IDLE -> ACCESS (mem_en) -> RESP (ack), so one per 3 cycles.
module tinycpu_mem_arb
  import tinycpu_pkg::*;
#(
  parameter int AW       = AW_DEF,
  parameter int DW       = DW_DEF,
  parameter int LOCK_MAX = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ack,
  input  logic          ldr_req,
  input  logic          ldr_we,
  input  logic [AW-1:0] ldr_addr,
  input  logic [DW-1:0] ldr_wdata,
  output logic [DW-1:0] ldr_rdata,
  output logic          ldr_ack,
  input  logic          ldr_lock,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          grant_ldr
);

  typedef struct packed {
    logic          ldr;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } hold_t;

  arb_state_e    state, state_nxt;
  hold_t         hold;
  logic          last_ldr;
  logic [7:0]    lock_cnt;
  logic          lock_hit;
  logic          pick_ldr, valid, grant, resp_rd;
  logic [DW-1:0] cpu_rdata_q, ldr_rdata_q;

  assign lock_hit = (lock_cnt >= 8'(LOCK_MAX));
  assign grant    = (state == IDLE) && valid;

  tinycpu_rr_pick u_pick (
    .cpu_req  (cpu_req),
    .ldr_req  (ldr_req),
    .last_ldr (last_ldr),
    .ldr_lock (ldr_lock),
    .lock_hit (lock_hit),
    .pick_ldr (pick_ldr),
    .valid    (valid)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state: a grant starts a fixed three-cycle sequence
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (valid) state_nxt = ACCESS;
      ACCESS:  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Latch the winner's request so requester inputs may change mid-flight
  always_ff @(posedge clk) begin
    if (reset) begin
      hold     <= '0;
      last_ldr <= 1'b1;
    end else if (grant) begin
      hold.ldr   <= pick_ldr;
      hold.we    <= pick_ldr ? ldr_we    : cpu_we;
      hold.addr  <= pick_ldr ? ldr_addr  : cpu_addr;
      hold.wdata <= pick_ldr ? ldr_wdata : cpu_wdata;
      last_ldr   <= pick_ldr;
    end
  end

  // Count lock-override grants taken while the CPU waits; bounded at LOCK_MAX
  always_ff @(posedge clk) begin
    if (reset || !ldr_lock)
      lock_cnt <= '0;
    else if (grant) begin
      if (pick_ldr == REQ_CPU)
        lock_cnt <= '0;
      else if (last_ldr && cpu_req && !lock_hit)
        lock_cnt <= lock_cnt + 8'd1;
    end
  end

  // Keep the last read data per port; writes leave it untouched
  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_rdata_q <= '0;
      ldr_rdata_q <= '0;
    end else if (resp_rd) begin
      if (hold.ldr) ldr_rdata_q <= mem_rdata;
      else          cpu_rdata_q <= mem_rdata;
    end
  end

  // SRAM strobe comes straight from the holding registers during ACCESS
  assign mem_en    = (state == ACCESS);
  assign mem_we    = mem_en && hold.we;
  assign mem_addr  = hold.addr;
  assign mem_wdata = hold.wdata;

  // SRAM output is live during RESP, so bypass it onto rdata alongside ack
  assign resp_rd   = (state == RESP) && !hold.we;
  assign cpu_rdata = (resp_rd && hold.ldr == REQ_CPU) ? mem_rdata : cpu_rdata_q;
  assign ldr_rdata = (resp_rd && hold.ldr == REQ_LDR) ? mem_rdata : ldr_rdata_q;

  // A reset landing on RESP swallows the ack
  assign cpu_ack   = (state == RESP) && !reset && (hold.ldr == REQ_CPU);
  assign ldr_ack   = (state == RESP) && !reset && (hold.ldr == REQ_LDR);
  assign grant_ldr = hold.ldr;

endmodule

// File: tb/tb_tinycpu_mem_arb.sv
// Bench for tinycpu_mem_arb: transaction-level reference model plus directed cases.
module tb_tinycpu_mem_arb;
  import tinycpu_pkg::*;

  localparam int LM = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cpu_req = 0, cpu_we = 0, ldr_req = 0, ldr_we = 0, ldr_lock = 0;
  logic [7:0] cpu_addr = 0, cpu_wdata = 0, ldr_addr = 0, ldr_wdata = 0;
  logic [7:0] cpu_rdata, ldr_rdata, mem_addr, mem_wdata;
  logic [7:0] mem_rdata = 8'h00;
  logic       cpu_ack, ldr_ack, mem_en, mem_we, grant_ldr;

  always #5 clk = ~clk;

  tinycpu_mem_arb #(.AW(8), .DW(8), .LOCK_MAX(LM)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_rdata(ldr_rdata), .ldr_ack(ldr_ack), .ldr_lock(ldr_lock),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .grant_ldr(grant_ldr)
  );

  // Synchronous SRAM, preloaded with addr ^ 8'hB5 on the first edge
  logic [7:0] sram [256];
  logic       sram_init = 1'b0;
  always @(posedge clk) begin
    if (!sram_init) begin
      for (int i = 0; i < 256; i++) sram[i] <= 8'(i) ^ 8'hB5;
      sram_init <= 1'b1;
    end else if (mem_en) begin
      if (mem_we) sram[mem_addr] <= mem_wdata;
      else        mem_rdata <= sram[mem_addr];
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: per-edge transaction progress (0 free, 1 mem cycle, 2 ack cycle)
  logic [7:0] ref_mem [256];
  int         m_phase = 0, m_lock = 0;
  logic       m_last = 1, m_win = 0, m_we = 0, m_grant = 0;
  logic [7:0] m_addr = 0, m_wdata = 0, m_cpu_rd = 0, m_ldr_rd = 0;
  logic       en_we = 0;
  logic [7:0] en_addr = 0, en_wdata = 0;

  initial begin
    bit both, win;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i) ^ 8'hB5;
    forever begin
      @(posedge clk);
      if (reset) begin
        if (m_phase == 1 && m_we) ref_mem[m_addr] = m_wdata;
        m_phase = 0; m_last = 1; m_lock = 0; m_grant = 0; m_win = 0;
        m_cpu_rd = 0; m_ldr_rd = 0; m_addr = 0; m_wdata = 0; m_we = 0;
      end else begin
        if (m_phase == 1) begin
          if (m_we)       ref_mem[m_addr] = m_wdata;
          else if (m_win) m_ldr_rd = ref_mem[m_addr];
          else            m_cpu_rd = ref_mem[m_addr];
          m_phase = 2;
        end else if (m_phase == 2) begin
          m_phase = 0;
        end else if (cpu_req || ldr_req) begin
          both = cpu_req && ldr_req;
          if (!both)                                   win = ldr_req;
          else if (ldr_lock && m_last && m_lock < LM)  win = 1;
          else                                         win = !m_last;
          if (both && ldr_lock && m_last && win) m_lock = (m_lock < LM) ? m_lock + 1 : LM;
          else if (!win)                         m_lock = 0;
          m_win   = win;
          m_we    = win ? ldr_we    : cpu_we;
          m_addr  = win ? ldr_addr  : cpu_addr;
          m_wdata = win ? ldr_wdata : cpu_wdata;
          m_last  = win;
          m_grant = win;
          m_phase = 1;
        end
        if (!ldr_lock) m_lock = 0;
      end
      #1;
      if (mem_en) begin en_addr = mem_addr; en_we = mem_we; en_wdata = mem_wdata; end
      chk("mem_en", mem_en, m_phase == 1);
      chk("mem_we", mem_we, m_phase == 1 && m_we);
      if (m_phase == 1) begin
        chk("mem_addr", mem_addr, m_addr);
        if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
      end
      chk("cpu_ack", cpu_ack, m_phase == 2 && !m_win && !reset);
      chk("ldr_ack", ldr_ack, m_phase == 2 && m_win && !reset);
      chk("cpu_rdata", cpu_rdata, m_cpu_rd);
      chk("ldr_rdata", ldr_rdata, m_ldr_rd);
      chk("grant_ldr", grant_ldr, m_grant);
      chk("lock_cnt", dut.lock_cnt, m_lock);
    end
  end

  // One transaction on a port; call on a falling edge, returns on the ack's falling edge
  task automatic txn(input bit ldr, input logic we, input logic [7:0] a, input logic [7:0] d,
                     output logic [7:0] rd, output int lat);
    logic ack;
    if (ldr) begin ldr_we = we; ldr_addr = a; ldr_wdata = d; ldr_req = 1; end
    else     begin cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_req = 1; end
    lat = 0;
    ack = 0;
    while (!ack && lat < 20) begin
      @(negedge clk);
      lat++;
      ack = ldr ? ldr_ack : cpu_ack;
    end
    chk(ldr ? "ldr_ack_seen" : "cpu_ack_seen", ack, 1);
    rd = ldr ? ldr_rdata : cpu_rdata;
    cpu_req = 0;
    ldr_req = 0;
  endtask

  // Both ports request continuously; record which port each of 6 acks went to
  task automatic race6(output logic [5:0] order, output int n);
    order = '0;
    n = 0;
    cpu_req = 1; ldr_req = 1;
    for (int c = 0; c < 60 && n < 6; c++) begin
      @(negedge clk);
      if (cpu_ack)      begin order[n] = 1'b0; n++; end
      else if (ldr_ack) begin order[n] = 1'b1; n++; end
    end
    cpu_req = 0; ldr_req = 0;
  endtask

  initial begin
    logic [7:0] rd;
    int         lat, n;
    logic [5:0] order;
    logic [5:0] exp_rr   = 6'b101010;  // bit i = 1 means i-th ack went to the loader
    logic [5:0] exp_lock = 6'b011111;

    // Reset held for three cycles
    repeat (3) @(negedge clk);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_acks", {cpu_ack, ldr_ack}, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_rdata", {cpu_rdata, ldr_rdata}, 0);
    chk("rst_grant_ldr", grant_ldr, 0);
    chk("rst_state", 32'(dut.state), 32'(IDLE));
    reset = 0;
    repeat (3) @(negedge clk);
    chk("idle_no_en", mem_en, 0);

    // CPU read of the preloaded location
    txn(0, 0, 8'h10, 8'h00, rd, lat);
    chk("cpu_rd_10", rd, 8'hA5);
    chk("cpu_rd_lat", lat, 2);
    chk("cpu_rd_en_addr", en_addr, 8'h10);
    chk("cpu_rd_en_we", en_we, 0);
    @(negedge clk);

    // Loader write then CPU read-back
    txn(1, 1, 8'h20, 8'h3C, rd, lat);
    chk("ldr_wr_en_we", en_we, 1);
    chk("ldr_wr_en_addr", en_addr, 8'h20);
    chk("ldr_wr_en_wdata", en_wdata, 8'h3C);
    chk("ldr_wr_rdata_held", ldr_rdata, 8'h00);
    @(negedge clk);
    txn(0, 0, 8'h20, 8'h00, rd, lat);
    chk("cpu_rd_20", rd, 8'h3C);
    @(negedge clk);

    // Fresh reset so the CPU takes the first tie, then alternate
    reset = 1;
    @(negedge clk);
    reset = 0;
    cpu_we = 0; cpu_addr = 8'h10; ldr_we = 0; ldr_addr = 8'h21;
    race6(order, n);
    chk("rr_count", n, 6);
    for (int i = 0; i < 6; i++) chk($sformatf("rr_order%0d", i), order[i], exp_rr[i]);
    repeat (2) @(negedge clk);

    // Lock burst: CPU granted last, so loader wins by round-robin then 4 locked grants
    txn(0, 0, 8'h05, 8'h00, rd, lat);
    chk("cpu_rd_05", rd, 8'h05 ^ 8'hB5);
    ldr_lock = 1;
    ldr_we = 1; ldr_addr = 8'h40; ldr_wdata = 8'h77;
    race6(order, n);
    chk("lock_count", n, 6);
    for (int i = 0; i < 6; i++) chk($sformatf("lock_order%0d", i), order[i], exp_lock[i]);
    chk("lock_cnt_after_cpu", dut.lock_cnt, 0);
    ldr_lock = 0;
    repeat (2) @(negedge clk);

    // Reset during ACCESS of a CPU read
    cpu_we = 0; cpu_addr = 8'h30; cpu_req = 1;
    @(negedge clk);
    chk("abort_in_access", mem_en, 1);
    reset = 1; cpu_req = 0;
    @(negedge clk);
    chk("abort_no_ack", cpu_ack, 0);
    chk("abort_state_idle", 32'(dut.state), 32'(IDLE));
    reset = 0;
    repeat (3) begin
      @(negedge clk);
      chk("abort_quiet", {cpu_ack, mem_en}, 0);
    end
    txn(0, 0, 8'h31, 8'h00, rd, lat);
    chk("post_abort_rd", rd, 8'h84);
    chk("post_abort_lat", lat, 2);
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tinycpu_mem_arb.md
# tinycpu_mem_arb

Two-port arbiter that shares the tinycpu's single-port program/data memory between the CPU core and the external loader/debug port. It sits between `toplevel` and the 256x8 synchronous SRAM. It serialises accesses through a 3-state FSM, uses round-robin priority on ties, and lets the loader lock the memory for bursts. A bounded lock keeps the CPU from starving.

## Interface
Parameters:
- `AW`, 8: address width (256-byte memory)
- `DW`, 8: data width
- `LOCK_MAX`, 16: max consecutive locked loader grants while the CPU is waiting (range 1..255)

Ports:
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  synchronous, active-high
- `cpu_req`  in  1  CPU access request, level, held until `cpu_ack`
- `cpu_we`  in  1  1 = write, 0 = read
- `cpu_addr`  in  AW  CPU address
- `cpu_wdata`  in  DW  CPU write data
- `cpu_rdata`  out  DW  read data, valid while `cpu_ack`=1
- `cpu_ack`  out  1  one-cycle completion pulse
- `ldr_req`, `ldr_we`, `ldr_addr`, `ldr_wdata`, `ldr_rdata`, `ldr_ack`: same as the CPU port, for the loader
- `ldr_lock`  in  1  loader requests bus retention across consecutive transactions
- `mem_en`  out  1  SRAM enable
- `mem_we`  out  1  SRAM write enable
- `mem_addr`  out  AW  SRAM address
- `mem_wdata`  out  DW  SRAM write data
- `mem_rdata`  in  DW  SRAM read data, valid 1 cycle after `mem_en`
- `grant_ldr`  out  1  current or last grant was the loader (debug visibility)

## Operation
- FSM is one-hot, 3 bits: IDLE=3'b001, ACCESS=3'b010, RESP=3'b100.
- IDLE:
  - If any request is present, pick a winner, latch its we/addr/wdata into holding registers, and go to ACCESS.
  - If no request is present, stay in IDLE.
- ACCESS: drive `mem_en`=1, plus `mem_we`, `mem_addr`, `mem_wdata` from the holding registers, for exactly one cycle. Go to RESP.
- RESP:
  - Register `mem_rdata` into the winner's rdata.
  - Pulse the winner's ack for one cycle.
  - Go to IDLE.
- On writes, ack is still pulsed; rdata is don't-care but must hold its previous value.
- Arbitration:
  - Single requester: it wins.
  - Both requesting: the port not granted last wins (round-robin via `last_ldr` flag).
  - Lock override: if `ldr_lock`=1 and the previous grant was the loader, the loader wins when it is requesting. This holds only while `lock_cnt` < `LOCK_MAX`; once the limit is reached and `cpu_req`=1, the CPU wins.
- `lock_cnt` (8 bits):
  - Increments on each locked loader grant made while `cpu_req`=1.
  - Clears on any CPU grant or when `ldr_lock`=0.
  - Saturates at `LOCK_MAX`.
- Requester rule: req must be low in the cycle after its ack, unless a new transaction is intended. req high in IDLE is always treated as a new request.
- Inputs changing while a transaction is in flight are ignored, because the holding registers are used.

## Timing
- Reset values:
  - state=IDLE, `last_ldr`=1 (CPU wins the first tie), `lock_cnt`=0.
  - All acks, `mem_en` and `mem_we` = 0.
  - `mem_addr`, `mem_wdata`, `cpu_rdata`, `ldr_rdata` = 0.
  - `grant_ldr`=0.
- Reset asserted mid-transaction aborts it: no ack is issued, and state returns to IDLE on the next edge.
- Latency: req sampled high in IDLE at edge N → `mem_en` high in cycle N+1 → ack high in cycle N+2 with rdata valid.
- Peak throughput is one access per 3 cycles.
- `mem_en` is never high in two consecutive cycles.
- At most one ack is high in any cycle.
- A losing requester keeps waiting. With both ports requesting continuously and no lock, acks alternate CPU, LDR, CPU, ...

## Structure
- Shared package `tinycpu_pkg`:
  - state encodings IDLE/ACCESS/RESP
  - requester IDs `REQ_CPU`=1'b0, `REQ_LDR`=1'b1
  - default `AW`/`DW`
- One sub-module, `tinycpu_rr_pick`: a combinational 2-way picker taking the two reqs, `last_ldr`, `ldr_lock` and the lock-limit flag, and producing `pick_ldr` and `valid`.
- FSM, holding registers and `lock_cnt` live in the top module.

## Test plan
- Reset hold 3 cycles, then release → all outputs 0 and state IDLE; no `mem_en` until a req is seen.
- CPU read of addr 8'h10 with SRAM preloaded 8'hA5 → `mem_en` at N+1 with `mem_addr`=8'h10 and `mem_we`=0; `cpu_ack`=1 and `cpu_rdata`=8'hA5 at N+2.
- Loader writes 8'h3C to 8'h20, then CPU reads 8'h20 → `mem_we`=1 with `mem_wdata`=8'h3C; CPU later receives 8'h3C.
- Both ports request continuously, 6 transactions → ack order is CPU, LDR, CPU, LDR, CPU, LDR.
- `ldr_lock`=1 with `LOCK_MAX`=4 and both ports requesting, after the first loader grant → 4 further consecutive loader grants, then a CPU grant; `lock_cnt` then reads 0.
- Reset asserted during ACCESS of a CPU read → no `cpu_ack`; IDLE next cycle; a new request is then served with normal 2-cycle latency.
